dmem_responder: RTL and testbench

- Data-memory responder that services load/store requests issued by the core's control/datapath.
- The core's control side raises a memory request; this block accepts it with a valid/ready handshake.
- It performs byte, half-word or word access on an internal word-organised RAM after a programmable wait-state count.
- It returns load data, sign- or zero-extended per funct3, or an error flag, with a second valid/ready handshake.

---
 rtl/dmem_responder.sv | 145 ++++++++++++++
 tb/tb_dmem_responder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store request at a time, waits a
// fixed number of busy cycles, accesses a word RAM and returns one response.
module dmem_responder #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [1:0]            state;
    logic [3:0]            cnt;
    logic                  lat_write;
    logic [2:0]            lat_f3;
    logic [31:0]           lat_addr;
    logic [31:0]           lat_wdata;
    logic [31:0]           mem [DEPTH];

    logic [ADDR_WIDTH-1:0] idx;
    logic [31:0]           word;
    logic [7:0]            bsel;
    logic [15:0]           hsel;
    logic [31:0]           load_val;
    logic [31:0]           store_data;
    logic [3:0]            store_be;
    logic                  misalign;
    logic                  out_of_range;
    logic                  bad_f3;
    logic                  err;
    logic                  access;

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign idx        = lat_addr[ADDR_WIDTH+1:2];
    assign word       = mem[idx];
    assign access     = (state == S_BUSY) && (cnt == '0);

    always_comb begin
        misalign     = ((lat_f3[1:0] == 2'd1) && lat_addr[0]) ||
                       ((lat_f3[1:0] == 2'd2) && (lat_addr[1:0] != 2'b00));
        out_of_range = (lat_addr >> (ADDR_WIDTH + 2)) != '0;
        bad_f3       = lat_write ? (lat_f3 > 3'd2)
                                 : ((lat_f3 == 3'd3) || (lat_f3[2:1] == 2'b11));
        err          = misalign || out_of_range || bad_f3;
    end

    always_comb begin
        bsel = word[8*lat_addr[1:0] +: 8];
        hsel = lat_addr[1] ? word[31:16] : word[15:0];
        case (lat_f3)
            3'd0:    load_val = {{24{bsel[7]}}, bsel};
            3'd1:    load_val = {{16{hsel[15]}}, hsel};
            3'd2:    load_val = word;
            3'd4:    load_val = {24'b0, bsel};
            3'd5:    load_val = {16'b0, hsel};
            default: load_val = '0;
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        case (lat_f3[1:0])
            2'd0: begin
                store_be   = 4'b0001 << lat_addr[1:0];
                store_data = {4{lat_wdata[7:0]}};
            end
            2'd1: begin
                store_be   = lat_addr[1] ? 4'b1100 : 4'b0011;
                store_data = {2{lat_wdata[15:0]}};
            end
            default: begin
                store_be   = 4'b1111;
                store_data = lat_wdata;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            lat_write  <= 1'b0;
            lat_f3     <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        lat_write <= req_write;
                        lat_f3    <= req_funct3;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        cnt       <= 4'(WAIT_CYCLES);
                        state     <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        resp_rdata <= (err || lat_write) ? '0 : load_val;
                        resp_err   <= err;
                        state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // RAM is not reset; the async reset forces state out of BUSY, cancelling any pending store.
    always_ff @(posedge clk) begin
        if (access && lat_write && !err) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (store_be[i]) begin
                    mem[idx][8*i +: 8] <= store_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: four instances with different wait-state counts.
module tb_dmem_responder;

    localparam int NI = 4;
    localparam int unsigned WS [NI] = '{1, 0, 15, 3};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid [NI];
    logic        req_ready [NI];
    logic        req_write [NI];
    logic [2:0]  req_funct3 [NI];
    logic [31:0] req_addr [NI];
    logic [31:0] req_wdata [NI];
    logic        resp_valid [NI];
    logic        resp_ready [NI];
    logic [31:0] resp_rdata [NI];
    logic        resp_err [NI];

    typedef struct {
        int          dut;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb [$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < NI; g++) begin : g_dut
            dmem_responder #(
                .ADDR_WIDTH (10),
                .WAIT_CYCLES(WS[g])
            ) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .req_valid (req_valid[g]),
                .req_ready (req_ready[g]),
                .req_write (req_write[g]),
                .req_funct3(req_funct3[g]),
                .req_addr  (req_addr[g]),
                .req_wdata (req_wdata[g]),
                .resp_valid(resp_valid[g]),
                .resp_ready(resp_ready[g]),
                .resp_rdata(resp_rdata[g]),
                .resp_err  (resp_err[g])
            );
        end
    endgenerate

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: sees the inputs that the coming posedge will use, so a handshake is caught exactly once.
    always @(negedge clk) begin : mon
        exp_t e;
        #1;
        for (int i = 0; i < NI; i++) begin
            if (rst_n && resp_valid[i] && resp_ready[i]) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_resp dut%0d: got 0x%08h expected none", i, resp_rdata[i]);
                end else begin
                    e = sb.pop_front();
                    chk("resp_dut", 32'(i), 32'(e.dut));
                    chk("resp_rdata", resp_rdata[i], e.rdata);
                    chk("resp_err", {31'b0, resp_err[i]}, {31'b0, e.err});
                end
            end
        end
    end

    task automatic send(input int d, input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input logic er, input bit push);
        int n = 0;
        while (!req_ready[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[d]) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout dut%0d: got req_ready=0 expected 1", d);
            return;
        end
        req_valid[d]  = 1'b1;
        req_write[d]  = w;
        req_funct3[d] = f3;
        req_addr[d]   = a;
        req_wdata[d]  = wd;
        if (push) sb.push_back(exp_t'{dut: d, rdata: rd, err: er});
        @(negedge clk);
        req_valid[d]  = 1'b0;
        req_addr[d]   = 32'hFFFF_FFFF;
        req_wdata[d]  = 32'h5A5A_5A5A;
    endtask

    // Entered at the negedge after the accept edge; counts edges until resp_valid.
    task automatic wait_resp(input int d);
        int k = 0;
        while (!resp_valid[d] && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("latency", 32'(k), 32'(WS[d] + 1));
        if (resp_valid[d] && resp_ready[d]) @(negedge clk);
    endtask

    task automatic txn(input int d, input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd, input logic er);
        send(d, w, f3, a, wd, rd, er, 1'b1);
        wait_resp(d);
    endtask

    task automatic cont(input int d);
        int n = 0;
        int k = 0;
        int acc [3];
        for (int j = 0; j < 3; j++) sb.push_back(exp_t'{dut: d, rdata: 32'h0, err: 1'b1});
        req_valid[d]  = 1'b1;
        req_write[d]  = 1'b0;
        req_funct3[d] = 3'd2;
        req_addr[d]   = 32'h3;
        while (k < 3 && n < 200) begin
            if (req_ready[d]) begin
                acc[k] = n;
                k++;
            end
            if (k < 3) begin
                @(negedge clk);
                n++;
            end
        end
        chk("cont_accepts", 32'(k), 32'd3);
        chk("cont_spacing1", 32'(acc[1] - acc[0]), 32'(WS[d] + 3));
        chk("cont_spacing2", 32'(acc[2] - acc[1]), 32'(WS[d] + 3));
        @(negedge clk);
        req_valid[d] = 1'b0;
        wait_resp(d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NI; i++) begin
            req_valid[i]  = 1'b0;
            req_write[i]  = 1'b0;
            req_funct3[i] = '0;
            req_addr[i]   = '0;
            req_wdata[i]  = '0;
            resp_ready[i] = 1'b1;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("rst_req_ready", {31'b0, req_ready[i]}, 32'd1);
            chk("rst_resp_valid", {31'b0, resp_valid[i]}, 32'd0);
            chk("rst_resp_rdata", resp_rdata[i], 32'd0);
            chk("rst_resp_err", {31'b0, resp_err[i]}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Basic word, byte and half-word traffic, WAIT_CYCLES=1
        txn(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        txn(0, 1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        txn(0, 1'b1, 3'd0, 32'h11, 32'h80, 32'h0, 1'b0);
        txn(0, 1'b0, 3'd0, 32'h11, 32'h0, 32'hFFFFFF80, 1'b0);
        txn(0, 1'b0, 3'd4, 32'h11, 32'h0, 32'h00000080, 1'b0);
        txn(0, 1'b0, 3'd1, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0);
        txn(0, 1'b0, 3'd2, 32'h10, 32'h0, 32'hDEAD80EF, 1'b0);

        // Error cases
        txn(0, 1'b0, 3'd2, 32'h13, 32'h0, 32'h0, 1'b1);
        txn(0, 1'b1, 3'd1, 32'h11, 32'h1234, 32'h0, 1'b1);
        txn(0, 1'b0, 3'd2, 32'h10, 32'h0, 32'hDEAD80EF, 1'b0);
        txn(0, 1'b0, 3'd3, 32'h10, 32'h0, 32'h0, 1'b1);
        txn(0, 1'b0, 3'd6, 32'h10, 32'h0, 32'h0, 1'b1);
        txn(0, 1'b0, 3'd7, 32'h10, 32'h0, 32'h0, 1'b1);
        txn(0, 1'b0, 3'd2, 32'h1000, 32'h0, 32'h0, 1'b1);
        txn(0, 1'b1, 3'd3, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1);
        txn(0, 1'b1, 3'd2, 32'h1010, 32'h11111111, 32'h0, 1'b1);
        txn(0, 1'b0, 3'd2, 32'h10, 32'h0, 32'hDEAD80EF, 1'b0);

        // More lanes and the top word
        txn(0, 1'b1, 3'd1, 32'h12, 32'hAAAA5555, 32'h0, 1'b0);
        txn(0, 1'b0, 3'd5, 32'h12, 32'h0, 32'h00005555, 1'b0);
        txn(0, 1'b0, 3'd1, 32'h10, 32'h0, 32'hFFFF80EF, 1'b0);
        txn(0, 1'b1, 3'd0, 32'h13, 32'hFFFFFF7F, 32'h0, 1'b0);
        txn(0, 1'b0, 3'd0, 32'h13, 32'h0, 32'h0000007F, 1'b0);
        txn(0, 1'b1, 3'd2, 32'hFFC, 32'hCAFEF00D, 32'h0, 1'b0);
        txn(0, 1'b0, 3'd5, 32'hFFE, 32'h0, 32'h0000CAFE, 1'b0);

        // Response backpressure with a second request waiting
        resp_ready[0] = 1'b0;
        send(0, 1'b0, 3'd2, 32'h10, 32'h0, 32'h7F5580EF, 1'b0, 1'b1);
        begin
            int k = 0;
            while (!resp_valid[0] && k < 40) begin
                @(negedge clk);
                k++;
            end
        end
        req_valid[0]  = 1'b1;
        req_write[0]  = 1'b0;
        req_funct3[0] = 3'd4;
        req_addr[0]   = 32'h10;
        sb.push_back(exp_t'{dut: 0, rdata: 32'h000000EF, err: 1'b0});
        repeat (5) begin
            @(negedge clk);
            chk("bp_resp_valid", {31'b0, resp_valid[0]}, 32'd1);
            chk("bp_resp_rdata", resp_rdata[0], 32'h7F5580EF);
            chk("bp_resp_err", {31'b0, resp_err[0]}, 32'd0);
            chk("bp_req_ready", {31'b0, req_ready[0]}, 32'd0);
        end
        resp_ready[0] = 1'b1;
        @(negedge clk);
        chk("bp_idle_after_resp", {31'b0, req_ready[0]}, 32'd1);
        chk("bp_valid_cleared", {31'b0, resp_valid[0]}, 32'd0);
        @(negedge clk);
        chk("bp_accepted_next", {31'b0, req_ready[0]}, 32'd0);
        req_valid[0] = 1'b0;
        wait_resp(0);

        // Latency and back-to-back spacing for WAIT_CYCLES=0 and 15
        txn(1, 1'b1, 3'd2, 32'h40, 32'h01020304, 32'h0, 1'b0);
        txn(1, 1'b0, 3'd0, 32'h43, 32'h0, 32'h00000001, 1'b0);
        cont(1);
        txn(2, 1'b1, 3'd2, 32'h40, 32'h8899AABB, 32'h0, 1'b0);
        txn(2, 1'b0, 3'd1, 32'h42, 32'h0, 32'hFFFF8899, 1'b0);
        cont(2);

        // Reset during BUSY of a store, WAIT_CYCLES=3
        txn(3, 1'b1, 3'd2, 32'h20, 32'h0BADF00D, 32'h0, 1'b0);
        send(3, 1'b1, 3'd2, 32'h20, 32'h12345678, 32'h0, 1'b0, 1'b0);
        chk("pre_rst_busy", {31'b0, req_ready[3]}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_req_ready", {31'b0, req_ready[3]}, 32'd1);
        chk("midrst_resp_valid", {31'b0, resp_valid[3]}, 32'd0);
        chk("midrst_resp_rdata", resp_rdata[3], 32'd0);
        chk("midrst_resp_err", {31'b0, resp_err[3]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        txn(3, 1'b0, 3'd2, 32'h20, 32'h0, 32'h0BADF00D, 1'b0);
        txn(0, 1'b0, 3'd2, 32'h10, 32'h0, 32'h7F5580EF, 1'b0);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
